// File: rtl/ctrl_salto_pc_pkg.sv
// rtl/ctrl_salto_pc_pkg.sv - shared PC-path encodings, FSM states and transfer-kind helpers
package ctrl_salto_pc_pkg;

  localparam logic [1:0] SEL_BRANCH = 2'b00;
  localparam logic [1:0] SEL_J      = 2'b01;
  localparam logic [1:0] SEL_JR     = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    K_BEQ = 2'd0,
    K_BNE = 2'd1,
    K_J   = 2'd2,
    K_JR  = 2'd3
  } kind_t;

  function automatic logic [1:0] kind_sel(input kind_t k);
    logic [1:0] s;
    case (k)
      K_J:     s = SEL_J;
      K_JR:    s = SEL_JR;
      default: s = SEL_BRANCH;
    endcase
    return s;
  endfunction

  function automatic logic kind_taken(input kind_t k, input logic eq);
    logic t;
    case (k)
      K_BEQ:   t = eq;
      K_BNE:   t = ~eq;
      default: t = 1'b1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ctrl_salto_pc_sat_counter.sv
// rtl/ctrl_salto_pc_sat_counter.sv - saturating up-counter with freeze
module ctrl_salto_pc_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             freeze_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !freeze_i && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ctrl_salto_pc.sv
// rtl/ctrl_salto_pc.sv - ID-stage branch/jump sequencer: PC select, IF/ID flush, rs-hazard stall
module ctrl_salto_pc
  import ctrl_salto_pc_pkg::*;
#(
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_id,
  input  logic             branch_eq,
  input  logic             branch_ne,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic             regs_equal,
  input  logic             rs_pending,
  input  logic             stall_ext,
  output logic [1:0]       sel_dire_salto,
  output logic             take_jump,
  output logic             flush_if_id,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             hazard_err
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t     state_q, state_d;
  kind_t      kind_q, kind_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] sel_q, sel_d;
  logic       hazard_q, hazard_d;

  kind_t      dec_kind, res_kind;
  logic       xfer, needs_rs, resolve, taken, stall;

  always_comb begin
    if (jump_reg)       dec_kind = K_JR;
    else if (jump)      dec_kind = K_J;
    else if (branch_eq) dec_kind = K_BEQ;
    else                dec_kind = K_BNE;
  end

  assign xfer     = valid_id & (jump_reg | jump | branch_eq | branch_ne);
  assign needs_rs = (dec_kind != K_J);

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    wait_cnt_d = wait_cnt_q;
    hazard_d   = hazard_q;
    resolve    = 1'b0;
    res_kind   = kind_q;
    stall      = 1'b0;
    if (reset) begin
      resolve = 1'b0;
    end else if (stall_ext) begin
      // Global freeze: hold everything; the ID instruction is re-seen when released.
      stall = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer && needs_rs && rs_pending) begin
            state_d    = WAIT;
            kind_d     = dec_kind;
            wait_cnt_d = 4'd1;
            stall      = 1'b1;
          end else if (xfer) begin
            resolve  = 1'b1;
            res_kind = dec_kind;
          end
        end
        WAIT: begin
          if (!rs_pending) begin
            resolve    = 1'b1;
            state_d    = IDLE;
            wait_cnt_d = 4'd0;
          end else if (wait_cnt_q >= MAX_W) begin
            // Operand never arrived: resolve on the stale comparator and flag it.
            hazard_d   = 1'b1;
            resolve    = 1'b1;
            state_d    = IDLE;
            wait_cnt_d = 4'd0;
          end else begin
            stall      = 1'b1;
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign taken = resolve & kind_taken(res_kind, regs_equal);

  always_comb begin
    sel_d = sel_q;
    if (resolve) begin
      sel_d = kind_sel(res_kind);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      kind_q     <= K_BEQ;
      wait_cnt_q <= 4'd0;
      sel_q      <= SEL_BRANCH;
      hazard_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      wait_cnt_q <= wait_cnt_d;
      sel_q      <= sel_d;
      hazard_q   <= hazard_d;
    end
  end

  ctrl_salto_pc_sat_counter #(
    .CNT_W (CNT_W)
  ) u_taken_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc_i    (taken),
    .freeze_i (stall_ext),
    .count_o  (taken_cnt)
  );

  assign sel_dire_salto = reset ? SEL_BRANCH : sel_d;
  assign take_jump      = taken;
  assign flush_if_id    = taken;
  assign stall_pc       = stall;
  assign stall_if_id    = stall;
  assign hazard_err     = hazard_q;

endmodule

// File: tb/tb_ctrl_salto_pc.sv
// tb/tb_ctrl_salto_pc.sv - directed vector bench for ctrl_salto_pc
module tb_ctrl_salto_pc;

  logic        clk = 1'b0;
  logic        reset, valid_id, branch_eq, branch_ne, jump, jump_reg;
  logic        regs_equal, rs_pending, stall_ext;
  logic [1:0]  sel_dire_salto;
  logic        take_jump, flush_if_id, stall_pc, stall_if_id, hazard_err;
  logic [15:0] taken_cnt;
  logic [1:0]  sel2;
  logic        take2, flush2, spc2, sif2, hz2;
  logic [1:0]  taken_cnt2;

  always #5 clk = ~clk;

  ctrl_salto_pc #(.MAX_WAIT(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .valid_id(valid_id), .branch_eq(branch_eq),
    .branch_ne(branch_ne), .jump(jump), .jump_reg(jump_reg), .regs_equal(regs_equal),
    .rs_pending(rs_pending), .stall_ext(stall_ext), .sel_dire_salto(sel_dire_salto),
    .take_jump(take_jump), .flush_if_id(flush_if_id), .stall_pc(stall_pc),
    .stall_if_id(stall_if_id), .taken_cnt(taken_cnt), .hazard_err(hazard_err)
  );

  ctrl_salto_pc #(.MAX_WAIT(3), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .valid_id(valid_id), .branch_eq(branch_eq),
    .branch_ne(branch_ne), .jump(jump), .jump_reg(jump_reg), .regs_equal(regs_equal),
    .rs_pending(rs_pending), .stall_ext(stall_ext), .sel_dire_salto(sel2),
    .take_jump(take2), .flush_if_id(flush2), .stall_pc(spc2),
    .stall_if_id(sif2), .taken_cnt(taken_cnt2), .hazard_err(hz2)
  );

  typedef struct {
    logic       rst, v, beq, bne, j, jr, eq, pend, ext;
    logic [1:0] sel;
    logic       take, stall, hz;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;

  task automatic add(input logic rst, v, beq, bne, j, jr, eq, pend, ext,
                     input logic [1:0] sel, input logic take, stall, hz);
    vec_t r;
    r.rst = rst; r.v = v; r.beq = beq; r.bne = bne; r.j = j; r.jr = jr;
    r.eq = eq; r.pend = pend; r.ext = ext;
    r.sel = sel; r.take = take; r.stall = stall; r.hz = hz;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    reset = r.rst; valid_id = r.v; branch_eq = r.beq; branch_ne = r.bne;
    jump = r.j; jump_reg = r.jr; regs_equal = r.eq; rs_pending = r.pend; stall_ext = r.ext;
  endtask

  initial begin
    vec_t z;
    z = '{rst:1'b1, default:1'b0};
    drive(z);
    repeat (2) @(posedge clk);
    #1;

    //   rst v beq bne j jr eq pnd ext   sel   take stall hz
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0); // reset state
    add(0, 1, 1, 0, 0, 0, 1, 0, 0,  2'b00, 1, 0, 0); // BEQ taken
    add(0, 1, 0, 1, 0, 0, 1, 0, 0,  2'b00, 0, 0, 0); // BNE not taken
    add(0, 1, 0, 0, 1, 0, 0, 0, 0,  2'b01, 1, 0, 0); // J
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  2'b01, 0, 0, 0); // sel holds
    add(0, 1, 0, 0, 0, 1, 0, 1, 0,  2'b01, 0, 1, 0); // JR waits
    add(0, 1, 0, 0, 0, 1, 0, 1, 0,  2'b01, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0, 0,  2'b10, 1, 0, 0); // JR resolves
    add(0, 1, 1, 0, 0, 0, 0, 1, 0,  2'b10, 0, 1, 0); // BEQ waits
    add(0, 0, 0, 1, 1, 0, 0, 1, 0,  2'b10, 0, 1, 0); // decode ignored in WAIT
    add(0, 0, 0, 0, 0, 0, 1, 1, 0,  2'b10, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0,  2'b00, 1, 0, 0); // forced resolve, eq=1
    add(0, 0, 0, 0, 0, 0, 1, 1, 0,  2'b00, 0, 0, 1); // hazard sticky
    add(0, 1, 0, 0, 1, 1, 0, 0, 1,  2'b00, 0, 1, 1); // J+JR under stall_ext
    add(0, 1, 0, 0, 1, 1, 0, 0, 1,  2'b00, 0, 1, 1);
    add(0, 1, 0, 0, 1, 1, 0, 0, 0,  2'b10, 1, 0, 1); // released: one take
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  2'b10, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0, 1, 1, 0,  2'b10, 0, 1, 1); // BNE waits
    add(0, 1, 0, 1, 0, 0, 1, 0, 1,  2'b10, 0, 1, 1); // frozen in WAIT
    add(0, 1, 0, 1, 0, 0, 0, 0, 0,  2'b00, 1, 0, 1); // BNE taken, eq=0
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 1); // reset; hazard clears at edge
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 1, 0,  2'b00, 0, 1, 0); // JR waits
    add(1, 1, 0, 0, 0, 1, 0, 1, 0,  2'b00, 0, 0, 0); // reset during WAIT
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0); // back in IDLE: no take

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk("sel_dire_salto", i, 32'(sel_dire_salto), 32'(vecs[i].sel));
      chk("take_jump",      i, 32'(take_jump),      32'(vecs[i].take));
      chk("flush_if_id",    i, 32'(flush_if_id),    32'(vecs[i].take));
      chk("stall_pc",       i, 32'(stall_pc),       32'(vecs[i].stall));
      chk("stall_if_id",    i, 32'(stall_if_id),    32'(vecs[i].stall));
      chk("hazard_err",     i, 32'(hazard_err),     32'(vecs[i].hz));
      chk("taken_cnt",      i, 32'(taken_cnt),      32'(exp_cnt));
      chk("taken_cnt_w2",   i, 32'(taken_cnt2),     32'((exp_cnt > 3) ? 3 : exp_cnt));
      @(posedge clk);
      #1;
      if (vecs[i].rst) exp_cnt = 0;
      else if (vecs[i].take) exp_cnt++;
    end

    // Five back-to-back J transfers: wide counter tracks, 2-bit counter saturates.
    reset = 1'b0; valid_id = 1'b1; jump = 1'b1; jump_reg = 1'b0;
    branch_eq = 1'b0; branch_ne = 1'b0; rs_pending = 1'b0; stall_ext = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("sat_take", 100 + k, 32'(take_jump), 32'd1);
      @(posedge clk);
      #1;
    end
    valid_id = 1'b0; jump = 1'b0;
    @(negedge clk);
    chk("sat_cnt16", 200, 32'(taken_cnt),  32'd5);
    chk("sat_cnt2",  201, 32'(taken_cnt2), 32'd3);
    chk("sat_sel",   202, 32'(sel_dire_salto), 32'd1);
    chk("sat_take0", 203, 32'(take_jump), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
